// File: rtl/rom_dl_writer_pkg.sv
// Shared definitions for the ROM download path: the ROM region map, the
// controller state encoding and the FIFO entry layout.
package rom_dl_writer_pkg;

   localparam logic [17:0] MAIN_BASE   = 18'h00000;
   localparam logic [17:0] SPCHIP_BASE = 18'h10000;
   localparam logic [17:0] BGCHIP_BASE = 18'h20000;
   localparam logic [17:0] SPCLUT_BASE = 18'h24000;
   localparam logic [17:0] BGCLUT_BASE = 18'h24100;
   localparam logic [17:0] PALET_BASE  = 18'h24200;
   localparam logic [17:0] ROM_END     = 18'h24220;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_DONE
   } dl_state_e;

   typedef struct packed {
      logic [17:0] addr;
      logic [7:0]  data;
   } dl_entry_t;

   // Host bytes outside the 18-bit ROM window or past the image end are ignored.
   function automatic logic addr_in_rom(input logic [24:0] had, input logic [17:0] rom_end);
      return (had[24:18] == 7'd0) && (had[17:0] < rom_end);
   endfunction

endpackage

// File: rtl/rom_dl_writer_fifo.sv
// Byte FIFO between the host capture stage and the download port: power-of-two
// depth, combinational head, synchronous clear.
module dl_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 26,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push & ~full & ~clr;
   assign do_pop  = pop & ~empty & ~clr;
   assign rdata   = mem[rd_ptr];

   // NOTE: storage has no reset; validity is defined only by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rom_dl_writer.sv
// Host-to-ROM download bridge: filters host bytes to the ROM map, buffers them
// and replays them on the download port with a running 16-bit checksum.
module rom_dl_writer
   import rom_dl_writer_pkg::dl_state_e, rom_dl_writer_pkg::dl_entry_t,
          rom_dl_writer_pkg::addr_in_rom, rom_dl_writer_pkg::S_IDLE,
          rom_dl_writer_pkg::S_LOAD, rom_dl_writer_pkg::S_FLUSH,
          rom_dl_writer_pkg::S_DONE;
#(
   parameter int          FDEPTH  = 4,
   parameter logic [17:0] ROM_END = rom_dl_writer_pkg::ROM_END
) (
   input  logic        cl,
   input  logic        rst_n,
   input  logic        dl_act,
   input  logic        hwr,
   input  logic [24:0] had,
   input  logic [7:0]  hdt,
   output logic        hwait,
   input  logic        hold,
   output logic        dlcl,
   output logic [17:0] dlad,
   output logic [7:0]  dldt,
   output logic        dlen,
   output logic        done,
   output logic [15:0] sum
);

   localparam int CW = $clog2(FDEPTH) + 1;

   dl_state_e     state;
   dl_entry_t     cap, head;
   logic          cap_vld, act_q, rise_pend, overflow, saw_last;
   logic          act_rise, act_fall, accept, start, pop;
   logic          f_empty, f_full;
   logic [CW-1:0] f_count;

   assign act_rise = dl_act & ~act_q;
   assign act_fall = ~dl_act & act_q;
   assign accept   = (state == S_LOAD) && hwr && addr_in_rom(had, ROM_END);
   assign start    = (act_rise && (state == S_IDLE || state == S_DONE)) ||
                     (rise_pend && state == S_DONE);
   assign pop      = ~f_empty & ~hold & ~start;
   assign hwait    = (state == S_FLUSH) || (f_count >= CW'(FDEPTH - 1));
   assign dlcl     = cl;

   dl_fifo #(
      .DEPTH (FDEPTH),
      .WIDTH ($bits(dl_entry_t))
   ) u_fifo (
      .clk   (cl),
      .rst_n (rst_n),
      .clr   (start),
      .push  (cap_vld),
      .wdata (cap),
      .pop   (pop),
      .rdata (head),
      .empty (f_empty),
      .full  (f_full),
      .count (f_count)
   );

   always_ff @(posedge cl or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         act_q     <= 1'b1;   // a level already high at reset release is not an edge
         rise_pend <= 1'b0;
         overflow  <= 1'b0;
         saw_last  <= 1'b0;
         cap_vld   <= 1'b0;
         cap       <= '0;
         dlad      <= '0;
         dldt      <= '0;
         dlen      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
      end else begin
         act_q   <= dl_act;
         cap_vld <= accept;
         if (accept) cap <= '{addr: had[17:0], data: hdt};
         dlen <= pop;
         if (pop) begin
            dlad <= head.addr;
            dldt <= head.data;
            sum  <= sum + 16'(head.data);
         end
         if (cap_vld && f_full) overflow <= 1'b1;
         if (accept && had[17:0] == ROM_END - 18'd1) saw_last <= 1'b1;

         case (state)
            S_LOAD:  if (act_fall) state <= S_FLUSH;
            S_FLUSH: begin
               if (act_rise) rise_pend <= 1'b1;
               if (f_empty && !cap_vld && !dlen) begin
                  state <= S_DONE;
                  done  <= saw_last & ~overflow;
               end
            end
            default: ;
         endcase

         // NOTE: the last non-blocking assignment wins, so a session start overrides the updates above.
         if (start) begin
            state     <= S_LOAD;
            cap_vld   <= 1'b0;
            sum       <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            saw_last  <= 1'b0;
            rise_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rom_dl_writer.sv
// Self-checking bench for rom_dl_writer: randomized host traffic against a
// queue-based model of which bytes must reappear on the download port.
module tb_rom_dl_writer;

   localparam int          FDEPTH = 4;
   localparam logic [17:0] RE     = 18'h00400;

   logic        cl = 1'b0;
   logic        rst_n = 1'b1;
   logic        dl_act = 1'b1;
   logic        hwr = 1'b0;
   logic [24:0] had = '0;
   logic [7:0]  hdt = '0;
   logic        hold = 1'b0;
   logic        hwait, dlcl, dlen, done;
   logic [17:0] dlad;
   logic [7:0]  dldt;
   logic [15:0] sum;

   int          checks = 0;
   int          errors = 0;
   logic [25:0] exp_q[$];
   logic [15:0] exp_sum = '0;
   logic [15:0] mon_sum = '0;
   logic [25:0] last_out = '0;
   int          dlen_cnt = 0;
   int          base_cnt = 0;
   int          acc_cnt = 0;
   bit          sess = 1'b0;
   bit          mon_en = 1'b0;
   bit          hold_rand = 1'b0;

   rom_dl_writer #(.FDEPTH(FDEPTH), .ROM_END(RE)) dut (
      .cl     (cl),
      .rst_n  (rst_n),
      .dl_act (dl_act),
      .hwr    (hwr),
      .had    (had),
      .hdt    (hdt),
      .hwait  (hwait),
      .hold   (hold),
      .dlcl   (dlcl),
      .dlad   (dlad),
      .dldt   (dldt),
      .dlen   (dlen),
      .done   (done),
      .sum    (sum)
   );

   always #5 cl = ~cl;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Download-port monitor: every DLEN must deliver the oldest outstanding accepted byte.
   initial forever begin
      @(negedge cl);
      if (mon_en) begin
         if (dlen) begin
            dlen_cnt++;
            check("dlen_has_pending_byte", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               logic [25:0] e;
               e = exp_q.pop_front();
               check("dlen_addr_data", {6'd0, dlad, dldt}, {6'd0, e});
               mon_sum += 16'(e[7:0]);
               check("sum_running", {16'd0, sum}, {16'd0, mon_sum});
            end
            last_out = {dlad, dldt};
         end else begin
            check("stable_without_dlen", {6'd0, dlad, dldt}, {6'd0, last_out});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before the sequence completed");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit force_wr,
                            input bit keep);
      int t = 0;
      if (hold_rand) hold = ($urandom_range(0, 3) == 0);
      while (!force_wr && hwait && t < 2000) begin
         if (hold_rand) hold = 1'b0;
         @(negedge cl);
         t++;
      end
      if (t >= 2000) check("hwait_release_timeout", {31'd0, hwait}, 32'd0);
      hwr = 1'b1;
      had = a;
      hdt = d;
      if (sess && keep && a[24:18] == 7'd0 && a[17:0] < RE) begin
         exp_q.push_back({a[17:0], d});
         exp_sum += 16'(d);
         acc_cnt++;
      end
      @(negedge cl);
      hwr = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge cl);
         t++;
      end
      check(tag, exp_q.size(), 32'd0);
      repeat (2) @(negedge cl);
   endtask

   task automatic start_session();
      hold_rand = 1'b1;
      hold      = 1'b0;
      dl_act    = 1'b0;
      @(negedge cl);
      dl_act = 1'b1;
      @(negedge cl);
      sess     = 1'b1;
      exp_sum  = '0;
      mon_sum  = '0;
      acc_cnt  = 0;
      base_cnt = dlen_cnt;
      check("start_sum_cleared", {16'd0, sum}, 32'd0);
      check("start_done_cleared", {31'd0, done}, 32'd0);
      check("start_hwait_low", {31'd0, hwait}, 32'd0);
   endtask

   task automatic end_session(input bit exp_done);
      int t = 0;
      hold_rand = 1'b0;
      hold      = 1'b0;
      dl_act    = 1'b0;
      sess      = 1'b0;
      @(negedge cl);
      check("hwait_in_flush", {31'd0, hwait}, 32'd1);
      while (hwait && t < 1000) begin
         @(negedge cl);
         t++;
      end
      check("flush_completes", {31'd0, hwait}, 32'd0);
      check("done_flag", {31'd0, done}, {31'd0, exp_done});
      check("sum_final", {16'd0, sum}, {16'd0, exp_sum});
      check("all_bytes_delivered", exp_q.size(), 32'd0);
      check("dlen_count", dlen_cnt - base_cnt, acc_cnt);
   endtask

   // Fill an empty FIFO under HOLD: backpressure must appear once three entries are stored.
   task automatic hold_burst(input int a);
      int base;
      hold_rand = 1'b0;
      hold      = 1'b0;
      wait_drain("drain_before_hold");
      hold = 1'b1;
      base = dlen_cnt;
      for (int k = 0; k < 4; k++) begin
         check("hwait_below_threshold", {31'd0, hwait}, 32'd0);
         send_byte(25'(a + k), 8'($urandom), 1'b0, 1'b1);
      end
      check("hwait_at_three_entries", {31'd0, hwait}, 32'd1);
      repeat (6) begin
         check("hwait_while_held", {31'd0, hwait}, 32'd1);
         @(negedge cl);
      end
      check("no_dlen_while_held", dlen_cnt, base);
      hold      = 1'b0;
      hold_rand = 1'b1;
   endtask

   task automatic stream(input int lo, input int hi, input bit hold_test, input bit bad);
      for (int a = lo; a < hi; a++) begin
         if (hold_test && a == 'h80) begin
            hold_burst(a);
            a += 3;
            continue;
         end
         if (bad && a == 'h200) begin
            send_byte(25'(RE), 8'hAA, 1'b0, 1'b1);
            send_byte(25'h0024220, 8'hAA, 1'b0, 1'b1);
            send_byte(25'h1000000, 8'hAA, 1'b0, 1'b1);
         end
         if ($urandom_range(0, 3) == 0) @(negedge cl);
         send_byte(25'(a), 8'($urandom), 1'b0, 1'b1);
      end
   endtask

   initial begin
      int t;
      int base;

      // Reset values, then a release with DL_ACT already high must not open a session.
      #1 rst_n = 1'b0;
      repeat (3) @(negedge cl);
      check("rst_dlad", {14'd0, dlad}, 32'd0);
      check("rst_dldt", {24'd0, dldt}, 32'd0);
      check("rst_dlen", {31'd0, dlen}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_hwait", {31'd0, hwait}, 32'd0);
      check("dlcl_low", {31'd0, dlcl}, {31'd0, cl});
      @(posedge cl);
      #1 check("dlcl_high", {31'd0, dlcl}, {31'd0, cl});
      @(negedge cl);
      rst_n    = 1'b1;
      last_out = '0;
      mon_en   = 1'b1;
      repeat (3) @(negedge cl);
      send_byte(25'h0000000, 8'h5A, 1'b0, 1'b1);
      repeat (6) @(negedge cl);
      check("no_session_after_release", dlen_cnt, 0);
      check("idle_hwait_low", {31'd0, hwait}, 32'd0);

      // Full image with random gaps/HOLD, a HOLD burst and out-of-map bytes.
      start_session();
      stream(0, int'(RE), 1'b1, 1'b1);
      end_session(1'b1);

      // Overflow: six forced writes into a stalled four-entry FIFO.
      start_session();
      hold_rand = 1'b0;
      hold      = 1'b1;
      for (int k = 0; k < 6; k++)
         send_byte(25'(k), 8'($urandom), 1'b1, k < 4);
      repeat (3) @(negedge cl);
      check("full_fifo_hwait", {31'd0, hwait}, 32'd1);
      hold      = 1'b0;
      hold_rand = 1'b1;
      stream(6, int'(RE), 1'b0, 1'b0);
      end_session(1'b0);

      // Partial image, flush stalled by HOLD, deferred session start.
      start_session();
      stream(0, 'h101, 1'b0, 1'b0);
      hold_rand = 1'b0;
      hold      = 1'b1;
      dl_act    = 1'b0;
      sess      = 1'b0;
      repeat (20) @(negedge cl);
      check("flush_stalled_by_hold", {31'd0, hwait}, 32'd1);
      check("no_done_while_stalled", {31'd0, done}, 32'd0);
      dl_act = 1'b1;
      repeat (2) @(negedge cl);
      hold = 1'b0;
      t = 0;
      while (hwait && t < 200) begin
         @(negedge cl);
         t++;
      end
      check("partial_flush_completes", {31'd0, hwait}, 32'd0);
      check("partial_done_low", {31'd0, done}, 32'd0);
      check("partial_sum", {16'd0, sum}, {16'd0, exp_sum});
      check("partial_all_delivered", exp_q.size(), 32'd0);
      check("partial_dlen_count", dlen_cnt - base_cnt, acc_cnt);
      @(negedge cl);
      sess     = 1'b1;
      exp_sum  = '0;
      mon_sum  = '0;
      acc_cnt  = 0;
      base_cnt = dlen_cnt;
      check("deferred_start_sum_cleared", {16'd0, sum}, 32'd0);
      hold_rand = 1'b1;
      send_byte(25'h0000010, 8'($urandom), 1'b0, 1'b1);
      send_byte(25'h0000011, 8'($urandom), 1'b0, 1'b1);
      end_session(1'b0);

      // Reset with two bytes buffered.
      start_session();
      stream(0, 3, 1'b0, 1'b0);
      hold_rand = 1'b0;
      hold      = 1'b0;
      wait_drain("drain_before_reset");
      hold = 1'b1;
      send_byte(25'h0000003, 8'($urandom), 1'b0, 1'b1);
      send_byte(25'h0000004, 8'($urandom), 1'b0, 1'b1);
      repeat (2) @(negedge cl);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("midrst_dlen", {31'd0, dlen}, 32'd0);
      check("midrst_dlad", {14'd0, dlad}, 32'd0);
      check("midrst_dldt", {24'd0, dldt}, 32'd0);
      check("midrst_sum", {16'd0, sum}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_hwait", {31'd0, hwait}, 32'd0);
      exp_q.delete();
      sess = 1'b0;
      hold = 1'b0;
      repeat (3) @(negedge cl);
      rst_n    = 1'b1;
      last_out = '0;
      mon_en   = 1'b1;
      base     = dlen_cnt;
      repeat (10) @(negedge cl);
      check("no_dlen_after_reset", dlen_cnt, base);
      check("hwait_after_reset", {31'd0, hwait}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
